// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: one-customer ATM session sequencer (card, language, PIN, services, timeout).
// Optional per-session withdrawal cap is enabled by defining ATM_WITHDRAW_LIMIT_EN.
module atm_session_ctrl #(
  parameter int unsigned BAL_W     = 8,
  parameter int unsigned AMT_W     = 5,
  parameter int unsigned PIN_W     = 4,
  parameter int unsigned CARD_W    = 8,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 15
`ifdef ATM_WITHDRAW_LIMIT_EN
  ,
  parameter int unsigned WD_LIMIT  = 20
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_valid,
  input  logic [CARD_W-1:0] card_no,
  input  logic              lang_valid,
  input  logic [1:0]        lang,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin,
  input  logic [PIN_W-1:0]  correct_pin,
  input  logic [BAL_W-1:0]  acct_balance,
  input  logic              svc_valid,
  input  logic [1:0]        svc,
  input  logic [AMT_W-1:0]  amount,
  input  logic              another_valid,
  input  logic              another,
  output logic [BAL_W-1:0]  balance,
  output logic              bal_wr,
  output logic [1:0]        lang_sel,
  output logic [2:0]        status,
  output logic              busy,
  output logic              card_retained
);
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam int unsigned SUM_W = BAL_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LANG    = 3'd1;
  localparam logic [2:0] S_PIN     = 3'd2;
  localparam logic [2:0] S_SERVICE = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_ANOTHER = 3'd5;

  localparam logic [2:0] ST_NONE     = 3'd0;
  localparam logic [2:0] ST_OK       = 3'd1;
  localparam logic [2:0] ST_BAD_PIN  = 3'd2;
  localparam logic [2:0] ST_FUNDS    = 3'd3;
  localparam logic [2:0] ST_OVF      = 3'd4;
  localparam logic [2:0] ST_TIMEOUT  = 3'd5;
  localparam logic [2:0] ST_RETAINED = 3'd6;
  localparam logic [2:0] ST_BAD_REQ  = 3'd7;

  localparam logic [1:0] SVC_END = 2'b00;
  localparam logic [1:0] SVC_DEP = 2'b01;
  localparam logic [1:0] SVC_WD  = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             bal_wr_q, bal_wr_d;
  logic [1:0]       lang_q, lang_d;
  logic [2:0]       status_q, status_d;
  logic             busy_q;
  logic             retained_q, retained_d;
  logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       svc_q, svc_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [SUM_W-1:0] sum;
  logic [BAL_W-1:0] amt_ext;
  logic             accepted;
`ifdef ATM_WITHDRAW_LIMIT_EN
  logic [BAL_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] acc_sum;
`endif

  // Next-state and next-output logic; timeout overrides any strobe in the same cycle.
  always_comb begin
    state_d    = state_q;
    balance_d  = balance_q;
    bal_wr_d   = 1'b0;
    lang_d     = lang_q;
    status_d   = status_q;
    retained_d = 1'b0;
    tries_d    = tries_q;
    svc_d      = svc_q;
    amt_d      = amt_q;
    accepted   = 1'b0;
    timer_d    = '0;
    tries_inc  = tries_q + TRY_W'(1);
    amt_ext    = BAL_W'(amt_q);
    sum        = {1'b0, balance_q} + SUM_W'(amt_q);
`ifdef ATM_WITHDRAW_LIMIT_EN
    acc_d      = acc_q;
    acc_sum    = {1'b0, acc_q} + SUM_W'(amt_q);
`endif
    if (state_q != S_IDLE && timer_q == TMR_W'(TIMEOUT - 1)) begin
      state_d  = S_IDLE;
      status_d = ST_TIMEOUT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_valid && card_no != '0) begin
            // A new card starts a fresh session: language choice is forgotten.
            balance_d = acct_balance;
            tries_d   = '0;
            status_d  = ST_NONE;
            lang_d    = 2'b00;
            state_d   = S_LANG;
`ifdef ATM_WITHDRAW_LIMIT_EN
            acc_d     = '0;
`endif
          end
        end
        S_LANG: begin
          if (lang_valid && (lang == 2'b01 || lang == 2'b10)) begin
            lang_d  = lang;
            state_d = S_PIN;
          end
        end
        S_PIN: begin
          if (pin_valid) begin
            accepted = 1'b1;
            if (pin == correct_pin) begin
              state_d = S_SERVICE;
            end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
              tries_d    = tries_inc;
              retained_d = 1'b1;
              status_d   = ST_RETAINED;
              state_d    = S_IDLE;
            end else begin
              tries_d  = tries_inc;
              status_d = ST_BAD_PIN;
            end
          end
        end
        S_SERVICE: begin
          if (svc_valid) begin
            accepted = 1'b1;
            svc_d    = svc;
            amt_d    = amount;
            if (svc == SVC_END) begin
              status_d = ST_OK;
              state_d  = S_IDLE;
            end else if (svc != 2'b11 && amount == '0) begin
              status_d = ST_BAD_REQ;
            end else begin
              state_d = S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state_d  = S_ANOTHER;
          status_d = ST_OK;
          case (svc_q)
            SVC_DEP: begin
              if (sum[BAL_W]) begin
                status_d = ST_OVF;
              end else begin
                balance_d = sum[BAL_W-1:0];
                bal_wr_d  = 1'b1;
              end
            end
            SVC_WD: begin
`ifdef ATM_WITHDRAW_LIMIT_EN
              if (acc_sum > SUM_W'(WD_LIMIT)) begin
                status_d = ST_BAD_REQ;
              end else
`endif
              if (amt_ext > balance_q) begin
                status_d = ST_FUNDS;
              end else begin
                balance_d = balance_q - amt_ext;
                bal_wr_d  = 1'b1;
`ifdef ATM_WITHDRAW_LIMIT_EN
                acc_d     = acc_sum[BAL_W-1:0];
`endif
              end
            end
            default: ;
          endcase
        end
        S_ANOTHER: begin
          if (another_valid) begin
            accepted = 1'b1;
            state_d  = another ? S_SERVICE : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Inactivity timer: restarts on any progress, counts only while a session is open.
    if (state_d == state_q && !accepted && state_q != S_IDLE) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      balance_q  <= '0;
      bal_wr_q   <= 1'b0;
      lang_q     <= 2'b00;
      status_q   <= ST_NONE;
      busy_q     <= 1'b0;
      retained_q <= 1'b0;
      tries_q    <= '0;
      timer_q    <= '0;
      svc_q      <= 2'b00;
      amt_q      <= '0;
`ifdef ATM_WITHDRAW_LIMIT_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      balance_q  <= balance_d;
      bal_wr_q   <= bal_wr_d;
      lang_q     <= lang_d;
      status_q   <= status_d;
      busy_q     <= (state_d != S_IDLE);
      retained_q <= retained_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      svc_q      <= svc_d;
      amt_q      <= amt_d;
`ifdef ATM_WITHDRAW_LIMIT_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign balance       = balance_q;
  assign bal_wr        = bal_wr_q;
  assign lang_sel      = lang_q;
  assign status        = status_q;
  assign busy          = busy_q;
  assign card_retained = retained_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed table, corner-case sequences and random traffic
// against a session-level reference model of the ATM controller.
module tb_atm_session_ctrl;
  localparam int unsigned BAL_W     = 8;
  localparam int unsigned AMT_W     = 5;
  localparam int unsigned PIN_W     = 4;
  localparam int unsigned CARD_W    = 8;
  localparam int unsigned MAX_TRIES = 3;
  localparam int unsigned TIMEOUT   = 15;
`ifdef ATM_WITHDRAW_LIMIT_EN
  localparam int unsigned WD_LIMIT  = 20;
`endif
  localparam logic [PIN_W-1:0] GOOD_PIN = 4'h7;

  localparam int K_NOP = 0, K_RST = 1, K_CARD = 2, K_LANG = 3, K_PIN = 4,
                 K_SVC = 5, K_ANO = 6, K_MIX = 7;
  localparam int P_IDLE = 0, P_LANG = 1, P_PIN = 2, P_SVC = 3, P_EXEC = 4, P_ANO = 5;

  typedef struct {
    logic              rst;
    logic              card_valid;
    logic [CARD_W-1:0] card_no;
    logic              lang_valid;
    logic [1:0]        lang;
    logic              pin_valid;
    logic [PIN_W-1:0]  pin;
    logic              svc_valid;
    logic [1:0]        svc;
    logic [AMT_W-1:0]  amount;
    logic              another_valid;
    logic              another;
  } in_t;

  typedef struct {
    in_t stim;
    int  bal;
    int  wr;
    int  st;
    int  busy;
    int  ret;
    int  lang;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, card_valid, lang_valid, pin_valid, svc_valid, another_valid, another;
  logic [CARD_W-1:0] card_no;
  logic [1:0]        lang, svc, lang_sel;
  logic [PIN_W-1:0]  pin, correct_pin;
  logic [BAL_W-1:0]  acct_balance, balance;
  logic [AMT_W-1:0]  amount;
  logic              bal_wr, busy, card_retained;
  logic [2:0]        status;

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  // Reference model: session phase, plain integer balances, activity timestamp.
  int m_phase = P_IDLE, m_bal = 0, m_wr = 0, m_st = 0, m_ret = 0, m_lang = 0;
  int m_tries = 0, m_last = 0, m_svc = 0, m_amt = 0, m_acc = 0;

  vec_t tbl[16];

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .BAL_W(BAL_W), .AMT_W(AMT_W), .PIN_W(PIN_W), .CARD_W(CARD_W),
    .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
`ifdef ATM_WITHDRAW_LIMIT_EN
    , .WD_LIMIT(WD_LIMIT)
`endif
  ) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_no(card_no),
    .lang_valid(lang_valid), .lang(lang), .pin_valid(pin_valid), .pin(pin),
    .correct_pin(correct_pin), .acct_balance(acct_balance), .svc_valid(svc_valid),
    .svc(svc), .amount(amount), .another_valid(another_valid), .another(another),
    .balance(balance), .bal_wr(bal_wr), .lang_sel(lang_sel), .status(status),
    .busy(busy), .card_retained(card_retained)
  );

  function automatic in_t mk(input int kind, input int a, input int b);
    in_t v;
    v = '{default: '0};
    case (kind)
      K_RST:  v.rst = 1'b1;
      K_CARD: begin v.card_valid = 1'b1; v.card_no = CARD_W'(a); end
      K_LANG: begin v.lang_valid = 1'b1; v.lang = 2'(a); end
      K_PIN:  begin v.pin_valid = 1'b1; v.pin = PIN_W'(a); end
      K_SVC:  begin v.svc_valid = 1'b1; v.svc = 2'(a); v.amount = AMT_W'(b); end
      K_ANO:  begin v.another_valid = 1'b1; v.another = 1'(a); end
      K_MIX: begin
        v.pin_valid = 1'b1; v.pin = GOOD_PIN; v.another_valid = 1'b1; v.another = 1'b1;
        v.lang_valid = 1'b1; v.lang = 2'b01; v.card_valid = 1'b1; v.card_no = 8'h05;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic model_step(input in_t v);
    int prev;
    bit act;
    m_wr  = 0;
    m_ret = 0;
    if (v.rst) begin
      m_phase = P_IDLE; m_bal = 0; m_st = 0; m_lang = 0; m_tries = 0; m_acc = 0;
      m_last = edge_no;
      return;
    end
    if (m_phase != P_IDLE && edge_no - m_last >= int'(TIMEOUT)) begin
      m_phase = P_IDLE; m_st = 5; m_last = edge_no;
      return;
    end
    prev = m_phase;
    act  = 0;
    case (m_phase)
      P_IDLE: if (v.card_valid && v.card_no != 0) begin
        m_bal = int'(acct_balance); m_tries = 0; m_st = 0; m_lang = 0; m_acc = 0;
        m_phase = P_LANG;
      end
      P_LANG: if (v.lang_valid && (v.lang == 1 || v.lang == 2)) begin
        m_lang = int'(v.lang); m_phase = P_PIN;
      end
      P_PIN: if (v.pin_valid) begin
        act = 1;
        if (v.pin == correct_pin) m_phase = P_SVC;
        else begin
          m_tries++;
          m_st = 2;
          if (m_tries == int'(MAX_TRIES)) begin m_ret = 1; m_st = 6; m_phase = P_IDLE; end
        end
      end
      P_SVC: if (v.svc_valid) begin
        act = 1; m_svc = int'(v.svc); m_amt = int'(v.amount);
        if (m_svc == 0) begin m_st = 1; m_phase = P_IDLE; end
        else if (m_svc != 3 && m_amt == 0) m_st = 7;
        else m_phase = P_EXEC;
      end
      P_EXEC: begin
        m_phase = P_ANO;
        m_st = 1;
        if (m_svc == 1) begin
          if (m_bal + m_amt > (1 << BAL_W) - 1) m_st = 4;
          else begin m_bal = m_bal + m_amt; m_wr = 1; end
        end else if (m_svc == 2) begin
`ifdef ATM_WITHDRAW_LIMIT_EN
          if (m_acc + m_amt > int'(WD_LIMIT)) m_st = 7;
          else
`endif
          if (m_amt > m_bal) m_st = 3;
          else begin m_bal = m_bal - m_amt; m_wr = 1; m_acc = m_acc + m_amt; end
        end
      end
      default: if (v.another_valid) begin
        act = 1; m_phase = v.another ? P_SVC : P_IDLE;
      end
    endcase
    if (act || m_phase != prev) m_last = edge_no;
  endtask

  task automatic apply(input in_t v);
    rst = v.rst; card_valid = v.card_valid; card_no = v.card_no;
    lang_valid = v.lang_valid; lang = v.lang; pin_valid = v.pin_valid; pin = v.pin;
    svc_valid = v.svc_valid; svc = v.svc; amount = v.amount;
    another_valid = v.another_valid; another = v.another;
    @(posedge clk);
    edge_no++;
    model_step(v);
    #1;
    chk("model_balance", int'(balance), m_bal);
    chk("model_bal_wr", int'(bal_wr), m_wr);
    chk("model_status", int'(status), m_st);
    chk("model_busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
    chk("model_retained", int'(card_retained), m_ret);
    chk("model_lang", int'(lang_sel), m_lang);
  endtask

  task automatic session(input int acct);
    acct_balance = BAL_W'(acct);
    apply(mk(K_CARD, 8'h5A, 0));
    apply(mk(K_LANG, 1, 0));
    apply(mk(K_PIN, int'(GOOD_PIN), 0));
  endtask

  initial begin
    correct_pin  = GOOD_PIN;
    acct_balance = 8'd100;
    // stim, balance, bal_wr, status, busy, card_retained, lang_sel
    tbl[0]  = '{mk(K_RST, 0, 0),     0,   0, 0, 0, 0, 0};
    tbl[1]  = '{mk(K_CARD, 0, 0),    0,   0, 0, 0, 0, 0};
    tbl[2]  = '{mk(K_CARD, 8'h5A, 0), 100, 0, 0, 1, 0, 0};
    tbl[3]  = '{mk(K_LANG, 3, 0),    100, 0, 0, 1, 0, 0};
    tbl[4]  = '{mk(K_LANG, 1, 0),    100, 0, 0, 1, 0, 1};
    tbl[5]  = '{mk(K_PIN, 7, 0),     100, 0, 0, 1, 0, 1};
    tbl[6]  = '{mk(K_SVC, 1, 0),     100, 0, 7, 1, 0, 1};
    tbl[7]  = '{mk(K_SVC, 1, 20),    100, 0, 7, 1, 0, 1};
    tbl[8]  = '{mk(K_NOP, 0, 0),     120, 1, 1, 1, 0, 1};
    tbl[9]  = '{mk(K_NOP, 0, 0),     120, 0, 1, 1, 0, 1};
    tbl[10] = '{mk(K_ANO, 1, 0),     120, 0, 1, 1, 0, 1};
    tbl[11] = '{mk(K_MIX, 0, 0),     120, 0, 1, 1, 0, 1};
    tbl[12] = '{mk(K_SVC, 3, 0),     120, 0, 1, 1, 0, 1};
    tbl[13] = '{mk(K_NOP, 0, 0),     120, 0, 1, 1, 0, 1};
    tbl[14] = '{mk(K_ANO, 0, 0),     120, 0, 1, 0, 0, 1};
    tbl[15] = '{mk(K_NOP, 0, 0),     120, 0, 1, 0, 0, 1};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].stim);
      chk($sformatf("tbl%0d_balance", i), int'(balance), tbl[i].bal);
      chk($sformatf("tbl%0d_bal_wr", i), int'(bal_wr), tbl[i].wr);
      chk($sformatf("tbl%0d_status", i), int'(status), tbl[i].st);
      chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
      chk($sformatf("tbl%0d_retained", i), int'(card_retained), tbl[i].ret);
      chk($sformatf("tbl%0d_lang", i), int'(lang_sel), tbl[i].lang);
    end

    // Insufficient funds, then exact withdrawal to zero.
    apply(mk(K_RST, 0, 0));
    session(10);
    apply(mk(K_SVC, 2, 15));
    apply(mk(K_NOP, 0, 0));
    chk("funds_status", int'(status), 3);
    chk("funds_bal_wr", int'(bal_wr), 0);
    chk("funds_balance", int'(balance), 10);
    apply(mk(K_ANO, 1, 0));
    apply(mk(K_SVC, 2, 10));
    apply(mk(K_NOP, 0, 0));
    chk("wd_zero_balance", int'(balance), 0);
    chk("wd_zero_bal_wr", int'(bal_wr), 1);

    // Deposit overflow.
    apply(mk(K_RST, 0, 0));
    session(250);
    apply(mk(K_SVC, 1, 10));
    apply(mk(K_NOP, 0, 0));
    chk("ovf_status", int'(status), 4);
    chk("ovf_balance", int'(balance), 250);
    chk("ovf_bal_wr", int'(bal_wr), 0);

    // PIN lockout.
    apply(mk(K_RST, 0, 0));
    acct_balance = 8'd50;
    apply(mk(K_CARD, 8'h33, 0));
    apply(mk(K_LANG, 2, 0));
    apply(mk(K_PIN, 3, 0));
    chk("lock_status1", int'(status), 2);
    apply(mk(K_PIN, 4, 0));
    chk("lock_status2", int'(status), 2);
    apply(mk(K_PIN, 5, 0));
    chk("lock_retained", int'(card_retained), 1);
    chk("lock_status3", int'(status), 6);
    chk("lock_busy", int'(busy), 0);
    apply(mk(K_NOP, 0, 0));
    chk("lock_pulse_end", int'(card_retained), 0);
    apply(mk(K_PIN, int'(GOOD_PIN), 0));
    chk("lock_late_pin_busy", int'(busy), 0);
    chk("lock_late_pin_status", int'(status), 6);

    // Timeout in SERVICE beats a strobe on the expiry cycle.
    apply(mk(K_RST, 0, 0));
    session(40);
    repeat (14) apply(mk(K_NOP, 0, 0));
    chk("to_busy_before", int'(busy), 1);
    apply(mk(K_SVC, 1, 5));
    chk("to_status", int'(status), 5);
    chk("to_busy_after", int'(busy), 0);
    chk("to_bal_wr", int'(bal_wr), 0);
    chk("to_balance", int'(balance), 40);

    // Reset on the EXEC cycle.
    apply(mk(K_RST, 0, 0));
    session(60);
    apply(mk(K_SVC, 1, 5));
    apply(mk(K_RST, 0, 0));
    chk("rst_exec_bal_wr", int'(bal_wr), 0);
    chk("rst_exec_balance", int'(balance), 0);
    chk("rst_exec_status", int'(status), 0);
    chk("rst_exec_busy", int'(busy), 0);
    chk("rst_exec_lang", int'(lang_sel), 0);

`ifdef ATM_WITHDRAW_LIMIT_EN
    // Accumulated withdrawal cap.
    apply(mk(K_RST, 0, 0));
    session(100);
    apply(mk(K_SVC, 2, 15));
    apply(mk(K_NOP, 0, 0));
    chk("lim_first_balance", int'(balance), 85);
    apply(mk(K_ANO, 1, 0));
    apply(mk(K_SVC, 2, 10));
    apply(mk(K_NOP, 0, 0));
    chk("lim_second_status", int'(status), 7);
    chk("lim_second_balance", int'(balance), 85);
    chk("lim_second_bal_wr", int'(bal_wr), 0);
`endif

    // Random traffic; every third block is sparse so the inactivity timeout fires.
    apply(mk(K_RST, 0, 0));
    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      dens = (blk % 3 == 2) ? 40 : 3;
      for (int c = 0; c < 200; c++) begin
        in_t v;
        v = mk(K_NOP, 0, 0);
        v.rst           = ($urandom_range(0, 299) == 0);
        v.card_valid    = ($urandom_range(0, dens - 1) == 0);
        v.card_no       = CARD_W'($urandom_range(0, 3));
        v.lang_valid    = ($urandom_range(0, dens - 1) == 0);
        v.lang          = 2'($urandom_range(0, 3));
        v.pin_valid     = ($urandom_range(0, dens - 1) == 0);
        v.pin           = ($urandom_range(0, 1) == 1) ? GOOD_PIN : PIN_W'($urandom_range(0, 15));
        v.svc_valid     = ($urandom_range(0, dens - 1) == 0);
        v.svc           = 2'($urandom_range(0, 3));
        v.amount        = AMT_W'($urandom_range(0, 31));
        v.another_valid = ($urandom_range(0, dens - 1) == 0);
        v.another       = 1'($urandom_range(0, 1));
        acct_balance    = BAL_W'($urandom_range(0, 255));
        apply(v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Parametrised ATM session controller. Sequences one customer session: card insert, language, PIN check with retry lockout, service selection, deposit/withdraw/balance execution, "another service?" loop, and inactivity timeout.
- Sits between the keypad/card-reader front end and the account store. Replaces the fixed-width single-session ATM FSM.
- Balance is read from the account store once per session and written back through a one-cycle write strobe.

Parameters:
- BAL_W, 8, balance width in bits.
- AMT_W, 5, transaction amount width in bits; must be <= BAL_W.
- PIN_W, 4, PIN width in bits.
- CARD_W, 8, card number width in bits.
- MAX_TRIES, 3, wrong PIN entries allowed before card retention (>= 1).
- TIMEOUT, 15, idle cycles in any non-IDLE state before the session is aborted (>= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- card_valid  in  1  card inserted; card_no is valid.
- card_no  in  CARD_W  card number; 0 is illegal and ignored.
- lang_valid  in  1  language entry strobe.
- lang  in  2  01 English, 10 German; 00 and 11 are ignored.
- pin_valid  in  1  PIN entry strobe.
- pin  in  PIN_W  entered PIN.
- correct_pin  in  PIN_W  PIN from the account store; stable while the session is active.
- acct_balance  in  BAL_W  stored balance; sampled on the card accept cycle.
- svc_valid  in  1  service entry strobe.
- svc  in  2  01 deposit, 10 withdraw, 11 balance, 00 end session.
- amount  in  AMT_W  amount; sampled together with svc_valid.
- another_valid  in  1  answer strobe in ANOTHER.
- another  in  1  1 = return to SERVICE, 0 = end session.
- balance  out  BAL_W  session balance register.
- bal_wr  out  1  one-cycle pulse; balance holds the new value to commit.
- lang_sel  out  2  latched language.
- status  out  3  result of the last operation: 0 none, 1 ok, 2 bad PIN, 3 insufficient funds, 4 overflow, 5 timeout, 6 card retained, 7 bad request.
- busy  out  1  high in any non-IDLE state.
- card_retained  out  1  one-cycle pulse on lockout.

Behaviour:
- Reset: state IDLE; balance 0; bal_wr 0; lang_sel 00; status 0; busy 0; card_retained 0; try counter and timer cleared. Reset mid-session aborts the session with no bal_wr.
- All strobes are sampled on the rising edge of clk. A strobe that does not belong to the current state is ignored.
- IDLE: card_valid with card_no != 0 loads balance <= acct_balance, clears the try counter, sets status 0, and goes to LANG.
- LANG: lang_valid with a legal lang latches lang_sel and goes to PIN.
- PIN:
  - pin_valid with a match goes to SERVICE.
  - pin_valid with a mismatch increments tries and sets status=2.
  - When tries reaches MAX_TRIES: pulse card_retained, set status=6, go to IDLE.
- SERVICE: svc_valid latches svc and amount.
  - svc=00: go to IDLE with status=1.
  - svc=01 or 10 with amount=0: status=7, stay in SERVICE.
  - Otherwise go to EXEC.
- EXEC takes exactly one cycle and then goes to ANOTHER:
  - Deposit: compute in BAL_W+1 bits. On carry, balance is unchanged, no bal_wr, status=4. Otherwise balance += amount, bal_wr=1, status=1.
  - Withdraw: amount > balance gives status=3 with balance unchanged. Otherwise balance -= amount, bal_wr=1, status=1.
  - Balance query: status=1, no bal_wr.
- Latency: bal_wr is asserted in the cycle after the EXEC entry edge, i.e. 2 edges after svc_valid.
- ANOTHER: another_valid with another=1 goes to SERVICE; with another=0 goes to IDLE. lang_sel persists until the next card.
- Timeout: the timer clears on every state change and on any accepted strobe, and increments otherwise in non-IDLE states. At count TIMEOUT-1: go to IDLE, status=5, no bal_wr. Timeout has priority over a strobe arriving in the same cycle.
- Simultaneous strobes: only the one relevant to the current state is honoured.

Optional Feature:
- Macro: ATM_WITHDRAW_LIMIT_EN.
- When defined:
  - Adds parameter WD_LIMIT (default 20) and a per-session accumulated-withdrawal register of BAL_W bits.
  - A withdraw that would push the accumulated total above WD_LIMIT is rejected with status=7, balance unchanged.
  - The accumulator clears on card accept and on reset.
- When undefined: no limit register; withdraw is bounded by balance only.

Test Plan:
- Happy deposit: acct_balance=100, card 0x5A, lang 01, correct PIN, svc 01 amount 20 → bal_wr with balance=120 two edges after svc_valid, status=1; another=0 → IDLE, busy=0.
- Insufficient funds: balance 10, withdraw 15 → status=3, no bal_wr, balance=10; then withdraw 10 → balance=0, bal_wr=1.
- Overflow: balance 250, BAL_W=8, deposit 10 → status=4, balance=250, no bal_wr.
- Lockout: three wrong PINs with MAX_TRIES=3 → status 2, 2, then card_retained pulse, status=6, state IDLE; a later correct PIN strobe is ignored.
- Timeout: stall in SERVICE for 15 cycles → IDLE with status=5; a svc_valid on the expiry cycle is ignored.
- Reset mid-EXEC: assert rst on the EXEC cycle → bal_wr=0 and all outputs at reset values. With ATM_WITHDRAW_LIMIT_EN and WD_LIMIT=20, withdrawals of 15 then 10 → second withdrawal gives status=7.
